sign_mag_accum: RTL and testbench

Multi-lane sign-application accumulator for the BitNet CiM datapath. Each beat carries one two's-complement partial result per lane plus a ternary weight code (+1, −1, 0). The block applies the weight, accumulates across a burst of beats, and on the last beat emits one sign-magnitude result per lane through a registered valid/ready output stage. It sits between the CiM array partial-sum readout and the activation/quantisation stage.

---
 rtl/sign_mag_pkg.sv | 27 ++
 rtl/sign_mag_accum_if.sv | 31 +++
 rtl/sign_mag_lane.sv | 96 +++++++++
 rtl/sign_mag_accum.sv | 87 ++++++++
 tb/tb_sign_mag_accum.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sign_mag_pkg.sv
// Shared widths, accumulator state encoding and saturation bounds for sign_mag_accum.
package sign_mag_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LANES  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_t;

  // Largest unsigned magnitude representable in w bits.
  function automatic logic [63:0] mag_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic signed [63:0] acc_smax(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_smin(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sign_mag_accum_if.sv
// Beat input and sign-magnitude result handshake bundle; master drives beats, slave is the accumulator.
interface sign_mag_accum_if
  import sign_mag_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_sign;
  logic [LANES-1:0]        in_zero;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_mag;
  logic [LANES-1:0]        out_sign;
  logic [LANES-1:0]        out_sat;
  logic [CNT_W-1:0]        out_beats;

  modport master (
    output in_valid, in_data, in_sign, in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_mag, out_sign, out_sat, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_sign, in_zero, in_last, out_ready,
    output in_ready, out_valid, out_mag, out_sign, out_sat, out_beats
  );
endinterface

// File: rtl/sign_mag_lane.sv
// One lane: ternary-weight term, burst accumulator and sign-magnitude result register.
// Result loads the cycle after the last-beat take; SIGN_MAG_ACCUM_SAT_EN selects saturate/clamp vs wrap.
module sign_mag_lane
  import sign_mag_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              take,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  input  logic              sign,
  input  logic              zero,
  output logic [DATA_W-1:0] mag,
  output logic              neg,
  output logic              sat
);
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] nxt;
  logic [DATA_W-1:0]       mag_nxt;

  // ACC_W > DATA_W, so negating the most negative input cannot overflow here.
  assign ext  = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};
  assign term = zero ? '0 : (sign ? -ext : ext);

`ifdef SIGN_MAG_ACCUM_SAT_EN
  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'(acc_smax(ACC_W));
  localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W+1)'(acc_smin(ACC_W));
  localparam logic [ACC_W-1:0]      MAG_MAX = ACC_W'(mag_max(DATA_W));

  logic signed [ACC_W:0] sum;
  logic [ACC_W-1:0]      abs_nxt;
  logic                  add_sat;
  logic                  clamp;
  logic                  sticky;

  assign sum = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};

  always_comb begin
    add_sat = 1'b0;
    nxt     = sum[ACC_W-1:0];
    if (sum > SUM_MAX) begin
      nxt     = SUM_MAX[ACC_W-1:0];
      add_sat = 1'b1;
    end else if (sum < SUM_MIN) begin
      nxt     = SUM_MIN[ACC_W-1:0];
      add_sat = 1'b1;
    end
  end

  assign abs_nxt = nxt[ACC_W-1] ? $unsigned(-nxt) : $unsigned(nxt);
  assign clamp   = abs_nxt > MAG_MAX;
  assign mag_nxt = clamp ? MAG_MAX[DATA_W-1:0] : abs_nxt[DATA_W-1:0];

  // Sticky records any saturation inside the burst so the emitted result reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      sat    <= 1'b0;
    end else if (take) begin
      if (last) begin
        sticky <= 1'b0;
        sat    <= sticky | add_sat | clamp;
      end else begin
        sticky <= sticky | add_sat;
      end
    end
  end
`else
  assign nxt     = acc + term;
  // Low bits of |nxt| equal the two's-complement negation of its low bits.
  assign mag_nxt = nxt[ACC_W-1] ? DATA_W'(-nxt[DATA_W-1:0]) : nxt[DATA_W-1:0];
  assign sat     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mag <= '0;
      neg <= 1'b0;
    end else if (take) begin
      if (last) begin
        acc <= '0;
        mag <= mag_nxt;
        neg <= nxt[ACC_W-1];
      end else begin
        acc <= nxt;
      end
    end
  end

endmodule

// File: rtl/sign_mag_accum.sv
// Multi-lane ternary-weight accumulator emitting sign-magnitude results per burst (SIGN_MAG_ACCUM_SAT_EN enables saturation).
// Result valid one cycle after last-beat accept; in_ready = !out_valid | out_ready, one beat per cycle when unblocked.
module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LANES  = DEF_LANES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  sign_mag_accum_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  accum_state_t            state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W-1:0]        beats_q;
  logic                    out_valid_q;
  logic                    take;
  logic                    emit;
  logic [LANES*DATA_W-1:0] mag_w;
  logic [LANES-1:0]        neg_w;
  logic [LANES-1:0]        sat_w;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign take         = bus.in_valid && bus.in_ready;
  assign emit         = take && bus.in_last;

  assign cnt_inc = (state == IDLE)       ? CNT_W'(1) :
                   (beat_cnt == CNT_MAX) ? CNT_MAX   : beat_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      beats_q  <= '0;
    end else if (take) begin
      if (bus.in_last) begin
        state    <= IDLE;
        beat_cnt <= '0;
        beats_q  <= cnt_inc;
      end else begin
        state    <= ACCUM;
        beat_cnt <= cnt_inc;
      end
    end
  end

  // A last beat taken alongside a drain reloads, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sign_mag_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .take  (take),
      .last  (bus.in_last),
      .data  (bus.in_data[i*DATA_W +: DATA_W]),
      .sign  (bus.in_sign[i]),
      .zero  (bus.in_zero[i]),
      .mag   (mag_w[i*DATA_W +: DATA_W]),
      .neg   (neg_w[i]),
      .sat   (sat_w[i])
    );
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_beats = beats_q;
  assign bus.out_mag   = mag_w;
  assign bus.out_sign  = neg_w;
  assign bus.out_sat   = sat_w;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Scoreboard bench for sign_mag_accum: a lane model queues expected results, a monitor pops them on each transfer.
`timescale 1ns/1ps
module tb_sign_mag_accum;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int LN = 4;
  localparam int CW = 8;
  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));

  typedef struct packed {
    logic [63:0] mag;
    logic [3:0]  sgn;
    logic [3:0]  sat;
    logic [7:0]  beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sign_mag_accum_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) bus();

  sign_mag_accum #(.DATA_W(DW), .ACC_W(AW), .LANES(LN), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   q[$];
  longint acc_m[4];
  bit     sticky_m[4];
  int     beats_m = 0;
  int     n_total = 0;
  int     n_bad = 0;
  bit     rand_ready = 1'b0;

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      acc_m[i]    = 0;
      sticky_m[i] = 1'b0;
    end
    beats_m = 0;
  endfunction

  function automatic void model_beat(input logic [63:0] d, input logic [3:0] s,
                                     input logic [3:0] z, input logic l);
    exp_t e;
    e = '0;
    beats_m = (beats_m < 255) ? beats_m + 1 : 255;
    for (int i = 0; i < 4; i++) begin
      longint t;
      longint n;
      longint a;
      bit add_sat;
      add_sat = 1'b0;
      t = z[i] ? 0 : longint'($signed(d[i*16 +: 16]));
      if (s[i] && !z[i]) t = -t;
      n = acc_m[i] + t;
`ifdef SIGN_MAG_ACCUM_SAT_EN
      if (n > AMAX) begin
        n = AMAX; add_sat = 1'b1;
      end else if (n < AMIN) begin
        n = AMIN; add_sat = 1'b1;
      end
`else
      n = n & 64'h0000_0000_00FF_FFFF;
      if (n > AMAX) n = n - 64'sh100_0000;
`endif
      if (!l) begin
        acc_m[i]    = n;
        sticky_m[i] = sticky_m[i] | add_sat;
      end else begin
        a = (n < 0) ? -n : n;
        e.sgn[i] = (n < 0);
`ifdef SIGN_MAG_ACCUM_SAT_EN
        e.sat[i] = sticky_m[i] | add_sat | (a > 65535);
        e.mag[i*16 +: 16] = (a > 65535) ? 16'hFFFF : a[15:0];
`else
        e.sat[i] = 1'b0;
        e.mag[i*16 +: 16] = a[15:0];
`endif
        acc_m[i]    = 0;
        sticky_m[i] = 1'b0;
      end
    end
    if (l) begin
      e.beats = beats_m[7:0];
      q.push_back(e);
      beats_m = 0;
    end
  endfunction

  // Realign to just after a rising edge; send() expects to start there.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] s, input logic [3:0] z, input logic l);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sign  = s;
    bus.in_zero  = z;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_total++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 50 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(d, s, z, l);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_last  = 1'($urandom);
  endtask

  // Result scoreboard: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_total++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL result: unexpected output mag=%h sign=%b beats=%0d, required none queued",
                 bus.out_mag, bus.out_sign, bus.out_beats);
      end else begin
        e = q.pop_front();
        if ({bus.out_mag, bus.out_sign, bus.out_sat, bus.out_beats} !== e) begin
          n_bad++;
          $display("FAIL result: got mag=%h sign=%b sat=%b beats=%0d required mag=%h sign=%b sat=%b beats=%0d",
                   bus.out_mag, bus.out_sign, bus.out_sat, bus.out_beats, e.mag, e.sgn, e.sat, e.beats);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_out_valid: got %b required 0", tag, bus.out_valid); end
    n_total++; if (bus.out_mag !== 64'h0) begin n_bad++; $display("FAIL %s_out_mag: got %h required 0", tag, bus.out_mag); end
    n_total++; if (bus.out_sign !== 4'h0) begin n_bad++; $display("FAIL %s_out_sign: got %b required 0", tag, bus.out_sign); end
    n_total++; if (bus.out_sat !== 4'h0) begin n_bad++; $display("FAIL %s_out_sat: got %b required 0", tag, bus.out_sat); end
    n_total++; if (bus.out_beats !== 8'h0) begin n_bad++; $display("FAIL %s_out_beats: got %0d required 0", tag, bus.out_beats); end
    n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %b required 1", tag, bus.in_ready); end
    q.delete();
    model_clear();
    rst_n = 1'b1;
    sync();
  endtask

  task automatic test_reset();
    reset_pulse("reset");
  endtask

  task automatic test_single();
    send(64'h0000_0000_0000_0005, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: out_valid=%b required 1", bus.out_valid); end
    n_total++; if ({bus.out_sign[0], bus.out_mag[15:0], bus.out_beats} !== {1'b1, 16'd5, 8'd1}) begin
      n_bad++; $display("FAIL single_lane0: sign=%b mag=%0d beats=%0d required 1/5/1", bus.out_sign[0], bus.out_mag[15:0], bus.out_beats);
    end
    sync();
  endtask

  task automatic test_multi();
    send(64'h0000_0000_0064_0000, 4'b0000, 4'b0000, 1'b0);
    send(64'h0000_0000_FED4_0000, 4'b0000, 4'b0000, 1'b0);
    send(64'h0000_0000_0032_0000, 4'b0010, 4'b0000, 1'b1);
    @(negedge clk);
    n_total++; if ({bus.out_valid, bus.out_sign[1], bus.out_mag[31:16], bus.out_beats} !== {1'b1, 1'b1, 16'd250, 8'd3}) begin
      n_bad++; $display("FAIL multi_lane1: valid=%b sign=%b mag=%0d beats=%0d required 1/1/250/3",
                        bus.out_valid, bus.out_sign[1], bus.out_mag[31:16], bus.out_beats);
    end
    sync();
  endtask

  task automatic test_corner();
    send(64'h1234_8000_0000_0000, 4'b1100, 4'b1000, 1'b1);
    @(negedge clk);
    n_total++; if ({bus.out_sign[2], bus.out_mag[47:32]} !== {1'b0, 16'h8000}) begin
      n_bad++; $display("FAIL corner_minneg: sign=%b mag=%h required 0/8000", bus.out_sign[2], bus.out_mag[47:32]);
    end
    n_total++; if ({bus.out_sign[3], bus.out_mag[63:48]} !== {1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL corner_zero: sign=%b mag=%h required 0/0000", bus.out_sign[3], bus.out_mag[63:48]);
    end
    sync();
  endtask

  task automatic test_overflow();
    logic [16:0] want;
`ifdef SIGN_MAG_ACCUM_SAT_EN
    want = {1'b1, 16'hFFFF};
`else
    want = {1'b0, 16'hFFFC};
`endif
    for (int k = 0; k < 4; k++) send(64'h0000_0000_0000_7FFF, 4'b0000, 4'b0000, 1'(k == 3));
    @(negedge clk);
    n_total++; if ({bus.out_sat[0], bus.out_mag[15:0]} !== want) begin
      n_bad++; $display("FAIL overflow_clamp: sat=%b mag=%h required sat=%b mag=%h", bus.out_sat[0], bus.out_mag[15:0], want[16], want[15:0]);
    end
    sync();
  endtask

  task automatic test_acc_sat();
    logic [17:0] want;
`ifdef SIGN_MAG_ACCUM_SAT_EN
    want = {1'b1, 1'b1, 16'h0001};
`else
    want = {1'b0, 1'b0, 16'h0000};
`endif
    for (int k = 0; k < 300; k++) send(64'h0000_0000_0000_8000, 4'b0001, 4'b0000, 1'b0);
    for (int k = 0; k < 256; k++) send(64'h0000_0000_0000_8000, 4'b0000, 4'b0000, 1'(k == 255));
    @(negedge clk);
    n_total++; if (bus.out_beats !== 8'd255) begin n_bad++; $display("FAIL beat_saturate: got %0d required 255", bus.out_beats); end
    n_total++; if ({bus.out_sat[0], bus.out_sign[0], bus.out_mag[15:0]} !== want) begin
      n_bad++; $display("FAIL acc_sticky: sat=%b sign=%b mag=%h required sat=%b sign=%b mag=%h",
                        bus.out_sat[0], bus.out_sign[0], bus.out_mag[15:0], want[17], want[16], want[15:0]);
    end
    sync();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(64'h0003_0000_0000_0009, 4'b1000, 4'b0000, 1'b1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_held: out_valid=%b required 1", bus.out_valid); end
    sync();
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0011_0000; bus.in_sign = 4'b0000;
    bus.in_zero = 4'b0000; bus.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: cycle %0d got %b required 0", k, bus.in_ready); end
      n_total++;
      if (q.size() == 0 || bus.out_valid !== 1'b1 ||
          {bus.out_mag, bus.out_sign, bus.out_sat, bus.out_beats} !== q[0]) begin
        n_bad++; $display("FAIL bp_stable: cycle %0d valid=%b mag=%h sign=%b beats=%0d not the held result",
                          k, bus.out_valid, bus.out_mag, bus.out_sign, bus.out_beats);
      end
    end
    bus.in_valid = 1'b0;
    sync();
    bus.out_ready = 1'b1;
    send(64'h0000_0000_0011_0000, 4'b0000, 4'b0000, 1'b1);
    send(64'h0000_0022_0000_0000, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_reload: out_valid=%b required 1", bus.out_valid); end
    sync();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(64'h0000_0000_0000_0100, 4'b0000, 4'b0000, 1'b1);
    sync();
    reset_pulse("rst_held");
    bus.out_ready = 1'b1;
    send(64'h0000_0000_0000_03E8, 4'b0000, 4'b0000, 1'b0);
    send(64'h0000_0000_0000_03E8, 4'b0000, 4'b0000, 1'b0);
    reset_pulse("rst_mid");
    send(64'h0000_0000_0000_0007, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    n_total++; if ({bus.out_mag[15:0], bus.out_beats} !== {16'd7, 8'd1}) begin
      n_bad++; $display("FAIL rst_restart: mag=%0d beats=%0d required 7/1", bus.out_mag[15:0], bus.out_beats);
    end
    sync();
  endtask

  task automatic test_back_to_back();
    time t0;
    bus.out_ready = 1'b1;
    t0 = $time;
    for (int k = 0; k < 6; k++) send({$urandom, $urandom}, 4'($urandom), 4'b0000, 1'b1);
    n_total++; if (($time - t0) !== 60) begin n_bad++; $display("FAIL throughput: 6 beats took %0t ns required 60", $time - t0); end
    rand_ready = 1'b1;
    for (int b = 0; b < 12; b++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) send({$urandom, $urandom}, 4'($urandom), 4'($urandom & $urandom), 1'(k == len - 1));
    end
    @(negedge clk);
    rand_ready = 1'b0;
    sync();
    bus.out_ready = 1'b1;
  endtask

  task automatic test_drain();
    repeat (5) @(negedge clk);
    n_total++; if (q.size() != 0) begin n_bad++; $display("FAIL drain: %0d results outstanding required 0", q.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sign = '0; bus.in_zero = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    model_clear();
    sync();
    test_reset();
    test_single();
    test_multi();
    test_corner();
    test_overflow();
    test_acc_sat();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_drain();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within 1 ms");
    $fatal(1);
  end

endmodule
